// File: rtl/clk_div_pkg.sv
// Shared definitions for the divided-clock duty monitor: FSM encoding and default counter width.
package clk_div_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } mon_state_e;

endpackage

// File: rtl/clk_duty_monitor_if.sv
// Measurement bus of the duty monitor: enable and clock-under-test in, period/high-time results out.
interface clk_duty_monitor_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             en;
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             duty_ok;
  logic             stuck;

  modport master (
    input  en,
    input  clk_in,
    output period,
    output high_time,
    output meas_valid,
    output duty_ok,
    output stuck
  );

  modport slave (
    output en,
    output clk_in,
    input  period,
    input  high_time,
    input  meas_valid,
    input  duty_ok,
    input  stuck
  );
endinterface

// File: rtl/edge_sync.sv
// Synchronises the asynchronous clock under test into clk and flags its rising/falling edges.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [SYNC_STAGES:0]   primed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      s_d_q    <= 1'b0;
      primed_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], clk_in};
      s_d_q    <= sync_q[SYNC_STAGES-1];
      primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Edges are only trusted once the whole chain holds real samples, so the
  // zeroed flops after reset cannot fake a rise while clk_in is already high.
  assign rise = primed_q[SYNC_STAGES] & s & ~s_d_q;
  assign fall = primed_q[SYNC_STAGES] & ~s & s_d_q;

endmodule

// File: rtl/clk_duty_monitor.sv
// Measures period and high time of a divided clock in clk cycles, checks ~50% duty, flags a stuck input.
module clk_duty_monitor
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  clk_duty_monitor_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [CNT_W:0] DIFF_ONE = {{CNT_W{1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic duty_within(input logic [CNT_W-1:0] hi, input logic [CNT_W-1:0] lo);
    logic signed [CNT_W:0] diff;
    diff = $signed({1'b0, hi}) - $signed({1'b0, lo});
    return (diff >= -DIFF_ONE) && (diff <= DIFF_ONE);
  endfunction

  logic s, rise, fall;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .clk_in(bus.clk_in),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             duty_ok_q, duty_ok_d;
  logic             stuck_q, stuck_d;

  always_comb begin
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    duty_ok_d    = duty_ok_q;
    stuck_d      = stuck_q;

    if (!bus.en) begin
      state_d  = WAIT_RISE;
      hi_cnt_d = '0;
      lo_cnt_d = '0;
      stuck_d  = 1'b0;
    end else begin
      if (rise) stuck_d = 1'b0;
      case (state_q)
        WAIT_RISE: begin
          if (rise) begin
            state_d  = HIGH;
            hi_cnt_d = CNT_ONE;
            lo_cnt_d = '0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d  = LOW;
            lo_cnt_d = CNT_ONE;
          end else if (s) begin
            hi_cnt_d = sat_inc(hi_cnt_q);
            if (hi_cnt_d == CNT_MAX) begin
              stuck_d = 1'b1;
              state_d = WAIT_RISE;
            end
          end
        end
        LOW: begin
          // Rise wins over saturation: a completed cycle is always published.
          if (rise) begin
            period_d     = hi_cnt_q + lo_cnt_q;
            high_time_d  = hi_cnt_q;
            duty_ok_d    = duty_within(hi_cnt_q, lo_cnt_q);
            meas_valid_d = 1'b1;
            state_d      = HIGH;
            hi_cnt_d     = CNT_ONE;
            lo_cnt_d     = '0;
          end else if (!s) begin
            lo_cnt_d = sat_inc(lo_cnt_q);
            if (lo_cnt_d == CNT_MAX) begin
              stuck_d = 1'b1;
              state_d = WAIT_RISE;
            end
          end
        end
        default: state_d = WAIT_RISE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_RISE;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      duty_ok_q    <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      duty_ok_q    <= duty_ok_d;
      stuck_q      <= stuck_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_time_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.duty_ok    = duty_ok_q;
  assign bus.stuck      = stuck_q;

endmodule
